// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the double-buffered frame buffer:
//   - default resolution / colour-depth constants
//   - clear-engine state encodings
//   - fb_pack_addr: builds the physical RAM address {page, Y, X}
// No ports (package).
// -----------------------------------------------------------------------------
package fb_pkg;

   localparam int FB_H_RES  = 160;
   localparam int FB_V_RES  = 120;
   localparam int FB_X_BITS = 8;
   localparam int FB_Y_BITS = 7;
   localparam int FB_BPP    = 1;

   typedef enum logic {
      FB_IDLE  = 1'b0,
      FB_CLEAR = 1'b1
   } fb_state_e;

   // Places the page bit directly above a packed {Y, X} pixel address.
   // Works on a 32-bit container so callers of any geometry can share it;
   // the caller keeps the low (1 + yx_bits) bits.
   function automatic logic [31:0] fb_pack_addr(input logic        page,
                                                input logic [31:0] yx,
                                                input int          yx_bits);
      return ({31'd0, page} << yx_bits) | yx;
   endfunction

endpackage

// File: rtl/fb_page_ram.sv
// -----------------------------------------------------------------------------
// fb_page_ram
// Single-clock simple dual-port RAM backing both frame-buffer pages.
//   i_clk      : clock
//   i_a_re     : port A read enable (read register holds when low)
//   i_a_we     : port A write enable
//   i_a_addr   : port A address
//   i_a_wdata  : port A write data
//   o_a_rdata  : port A registered read data, read-before-write
//   i_b_addr   : port B address
//   o_b_rdata  : port B registered read data
// Contents are not reset.
// -----------------------------------------------------------------------------
module fb_page_ram #(
   parameter int AW = 16,
   parameter int DW = 1
) (
   input  logic          i_clk,
   input  logic          i_a_re,
   input  logic          i_a_we,
   input  logic [AW-1:0] i_a_addr,
   input  logic [DW-1:0] i_a_wdata,
   output logic [DW-1:0] o_a_rdata,
   input  logic [AW-1:0] i_b_addr,
   output logic [DW-1:0] o_b_rdata
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] r_mem [0:DEPTH-1];
   logic [DW-1:0] r_a_rdata;
   logic [DW-1:0] r_b_rdata;

   // Port A: the read samples the old word before the write lands
   always_ff @(posedge i_clk) begin
      if (i_a_re) begin
         r_a_rdata <= r_mem[i_a_addr];
      end
      if (i_a_we) begin
         r_mem[i_a_addr] <= i_a_wdata;
      end
   end

   // Port B: free-running registered read
   always_ff @(posedge i_clk) begin
      r_b_rdata <= r_mem[i_b_addr];
   end

   assign o_a_rdata = r_a_rdata;
   assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/frame_buffer_dp.sv
// -----------------------------------------------------------------------------
// frame_buffer_dp
// Double-buffered frame buffer with a hardware clear engine.
//   i_clk / i_reset          : clock, synchronous active-high reset
//   i_a_addr/_data_in/_we    : CPU port, {Y,X} address, writes the back page
//   o_a_data_out             : registered back-page read (read-before-write)
//   o_a_busy                 : clear engine owns port A
//   i_b_addr / o_b_data_out  : scan-out port, registered front-page read
//   i_clear_req/_colour      : start filling the back page with a colour
//   i_swap_req / i_frame_start : page exchange, applied at frame boundaries
//   o_swap_pending / o_front_page : swap status, page shown on port B
// -----------------------------------------------------------------------------
module frame_buffer_dp
   import fb_pkg::*;
#(
   parameter int H_RES  = FB_H_RES,
   parameter int V_RES  = FB_V_RES,
   parameter int X_BITS = FB_X_BITS,
   parameter int Y_BITS = FB_Y_BITS,
   parameter int BPP    = FB_BPP
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [X_BITS+Y_BITS-1:0] i_a_addr,
   input  logic [BPP-1:0]           i_a_data_in,
   input  logic                     i_a_we,
   output logic [BPP-1:0]           o_a_data_out,
   output logic                     o_a_busy,
   input  logic [X_BITS+Y_BITS-1:0] i_b_addr,
   output logic [BPP-1:0]           o_b_data_out,
   input  logic                     i_clear_req,
   input  logic [BPP-1:0]           i_clear_colour,
   input  logic                     i_swap_req,
   input  logic                     i_frame_start,
   output logic                     o_swap_pending,
   output logic                     o_front_page
);

   localparam int PIX_AW = X_BITS + Y_BITS;
   localparam int RAM_AW = PIX_AW + 1;
   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(H_RES - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_RES - 1);

   fb_state_e         r_state;
   logic [X_BITS-1:0] r_cx;
   logic [Y_BITS-1:0] r_cy;
   logic [BPP-1:0]    r_colour;
   logic              r_front;
   logic              r_pending;
   logic              r_a_zero;   // last port A read was out of range
   logic              r_b_zero;   // last port B read was out of range

   logic              w_a_in_range;
   logic              w_b_in_range;
   logic [31:0]       w_pack_a;
   logic [31:0]       w_pack_b;
   logic [31:0]       w_pack_clr;
   logic              w_ram_re;
   logic              w_ram_we;
   logic [RAM_AW-1:0] w_ram_addr;
   logic [BPP-1:0]    w_ram_wdata;
   logic [BPP-1:0]    w_ram_a_rdata;
   logic [BPP-1:0]    w_ram_b_rdata;
   logic              w_unused;

   assign w_a_in_range = (i_a_addr[X_BITS-1:0] <= X_LAST) && (i_a_addr[PIX_AW-1:X_BITS] <= Y_LAST);
   assign w_b_in_range = (i_b_addr[X_BITS-1:0] <= X_LAST) && (i_b_addr[PIX_AW-1:X_BITS] <= Y_LAST);

   // Port A and the clear engine target the back page, port B the front page
   assign w_pack_a   = fb_pack_addr(~r_front, {{(32-PIX_AW){1'b0}}, i_a_addr}, PIX_AW);
   assign w_pack_clr = fb_pack_addr(~r_front, {{(32-PIX_AW){1'b0}}, r_cy, r_cx}, PIX_AW);
   assign w_pack_b   = fb_pack_addr(r_front, {{(32-PIX_AW){1'b0}}, i_b_addr}, PIX_AW);
   assign w_unused   = ^{w_pack_a[31:RAM_AW], w_pack_clr[31:RAM_AW], w_pack_b[31:RAM_AW]};

   // RAM port A ownership: CPU in IDLE, clear engine in CLEAR.
   // Writes are suppressed on a reset edge so an aborted clear stops cleanly.
   always_comb begin
      w_ram_re    = 1'b0;
      w_ram_we    = 1'b0;
      w_ram_addr  = w_pack_a[RAM_AW-1:0];
      w_ram_wdata = i_a_data_in;
      if (i_reset) begin
         w_ram_re = 1'b0;
         w_ram_we = 1'b0;
      end else begin
         case (r_state)
            FB_IDLE: begin
               w_ram_re = 1'b1;
               w_ram_we = i_a_we & w_a_in_range;
            end
            FB_CLEAR: begin
               w_ram_we    = 1'b1;
               w_ram_addr  = w_pack_clr[RAM_AW-1:0];
               w_ram_wdata = r_colour;
            end
            default: begin
               w_ram_re = 1'b0;
               w_ram_we = 1'b0;
            end
         endcase
      end
   end

   fb_page_ram #(
      .AW (RAM_AW),
      .DW (BPP)
   ) u_ram (
      .i_clk     (i_clk),
      .i_a_re    (w_ram_re),
      .i_a_we    (w_ram_we),
      .i_a_addr  (w_ram_addr),
      .i_a_wdata (w_ram_wdata),
      .o_a_rdata (w_ram_a_rdata),
      .i_b_addr  (w_pack_b[RAM_AW-1:0]),
      .o_b_rdata (w_ram_b_rdata)
   );

   // Clear FSM, swap control and read-range flags
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= FB_IDLE;
         r_cx      <= '0;
         r_cy      <= '0;
         r_colour  <= '0;
         r_front   <= 1'b0;
         r_pending <= 1'b0;
         r_a_zero  <= 1'b1;
         r_b_zero  <= 1'b1;
      end else begin
         r_b_zero <= ~w_b_in_range;
         case (r_state)
            FB_IDLE: begin
               r_a_zero <= ~w_a_in_range;
               if (i_clear_req) begin
                  r_state  <= FB_CLEAR;
                  r_colour <= i_clear_colour;
                  r_cx     <= '0;
                  r_cy     <= '0;
               end
            end
            FB_CLEAR: begin
               // X-major raster; the last pixel returns the FSM to IDLE
               if (r_cx == X_LAST) begin
                  r_cx <= '0;
                  if (r_cy == Y_LAST) begin
                     r_cy    <= '0;
                     r_state <= FB_IDLE;
                  end else begin
                     r_cy <= r_cy + Y_BITS'(1);
                  end
               end else begin
                  r_cx <= r_cx + X_BITS'(1);
               end
            end
            default: r_state <= FB_IDLE;
         endcase
         // A request arriving with FRAME_START counts as already pending
         if (i_frame_start && (r_pending || i_swap_req) && (r_state == FB_IDLE)) begin
            r_front   <= ~r_front;
            r_pending <= 1'b0;
         end else if (i_swap_req) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign o_a_data_out   = r_a_zero ? {BPP{1'b0}} : w_ram_a_rdata;
   assign o_b_data_out   = r_b_zero ? {BPP{1'b0}} : w_ram_b_rdata;
   assign o_a_busy       = (r_state == FB_CLEAR);
   assign o_swap_pending = r_pending;
   assign o_front_page   = r_front;

endmodule

// File: tb/tb_frame_buffer_dp.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_dp
// Directed bench for frame_buffer_dp at default geometry (160x120, 1 bpp).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_frame_buffer_dp;

   localparam int NPIX = 160 * 120;

   logic        clk = 1'b0;
   logic        reset;
   logic [14:0] a_addr;
   logic        a_din;
   logic        a_we;
   logic        a_dout;
   logic        a_busy;
   logic [14:0] b_addr;
   logic        b_dout;
   logic        clear_req;
   logic        clear_colour;
   logic        swap_req;
   logic        frame_start;
   logic        swap_pending;
   logic        front_page;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   frame_buffer_dp dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_a_addr       (a_addr),
      .i_a_data_in    (a_din),
      .i_a_we         (a_we),
      .o_a_data_out   (a_dout),
      .o_a_busy       (a_busy),
      .i_b_addr       (b_addr),
      .o_b_data_out   (b_dout),
      .i_clear_req    (clear_req),
      .i_clear_colour (clear_colour),
      .i_swap_req     (swap_req),
      .i_frame_start  (frame_start),
      .o_swap_pending (swap_pending),
      .o_front_page   (front_page)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] pix(input int x, input int y);
      return 15'((y << 8) | x);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until the clear engine drops A_BUSY; n counts busy samples
   task automatic wait_idle(output int n);
      n = 0;
      while (a_busy && n < 20000) begin
         n++;
         step();
      end
   endtask

   initial begin
      int n;
      int bad;
      int p;
      int plist [7] = '{0, 250, 499, 500, 501, 1000, NPIX-1};

      reset = 1'b1; a_addr = '0; a_din = 1'b0; a_we = 1'b0; b_addr = '0;
      clear_req = 1'b0; clear_colour = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
      repeat (3) step();
      check("rst_a_data", 32'(a_dout), 0);
      check("rst_b_data", 32'(b_dout), 0);
      check("rst_busy", 32'(a_busy), 0);
      check("rst_pending", 32'(swap_pending), 0);
      check("rst_front", 32'(front_page), 0);
      reset = 1'b0;

      // Page 1 gets 0 at (5,3); swap with REQ and FRAME_START together
      a_addr = pix(5, 3); a_din = 1'b0; a_we = 1'b1; step(); a_we = 1'b0;
      swap_req = 1'b1; frame_start = 1'b1; step(); swap_req = 1'b0; frame_start = 1'b0;
      check("simul_swap_front", 32'(front_page), 1);
      check("simul_swap_pending", 32'(swap_pending), 0);

      // Back page is now page 0: write 1 at (5,3), read back on A, not on B
      a_din = 1'b1; a_we = 1'b1; step(); a_we = 1'b0; step();
      check("a_readback", 32'(a_dout), 1);
      b_addr = pix(5, 3); step();
      check("b_front_untouched", 32'(b_dout), 0);

      // Deferred swap 10 cycles after the request
      swap_req = 1'b1; step(); swap_req = 1'b0;
      check("swap_pending_set", 32'(swap_pending), 1);
      check("swap_front_held", 32'(front_page), 1);
      repeat (9) step();
      frame_start = 1'b1; step(); frame_start = 1'b0;
      check("swap_front", 32'(front_page), 0);
      check("swap_pending_clr", 32'(swap_pending), 0);
      step();
      check("b_after_swap", 32'(b_dout), 1);

      // Read-before-write on page 1 at (5,3) (holds 0)
      a_addr = pix(5, 3); a_din = 1'b1; a_we = 1'b1; step(); a_we = 1'b0;
      check("a_rbw_old", 32'(a_dout), 0);
      step();
      check("a_rbw_new", 32'(a_dout), 1);

      // Out-of-range addresses: writes dropped, reads 0 on both ports
      a_addr = pix(160, 0); a_we = 1'b1; step(); a_we = 1'b0;
      check("a_oor_x_wr", 32'(a_dout), 0);
      step();
      check("a_oor_x_rd", 32'(a_dout), 0);
      a_addr = pix(0, 120); a_we = 1'b1; step(); a_we = 1'b0;
      check("a_oor_y_wr", 32'(a_dout), 0);
      step();
      check("a_oor_y_rd", 32'(a_dout), 0);
      b_addr = pix(160, 0); step();
      check("b_oor_x", 32'(b_dout), 0);
      b_addr = pix(0, 120); step();
      check("b_oor_y", 32'(b_dout), 0);

      // Clear page 1 to 1; a same-cycle write of 0 at (5,3) must be overwritten
      a_addr = pix(5, 3); a_din = 1'b0; a_we = 1'b1;
      clear_colour = 1'b1; clear_req = 1'b1; step();
      clear_req = 1'b0; a_we = 1'b0; clear_colour = 1'b0;
      check("clr_busy_rise", 32'(a_busy), 1);
      check("clr_a_rbw", 32'(a_dout), 1);
      n = 0;
      while (a_busy && n < 20000) begin
         n++;
         if (n == 100) begin a_addr = pix(2, 0); a_din = 1'b0; a_we = 1'b1; end
         if (n == 101) a_we = 1'b0;
         if (n == 200) begin swap_req = 1'b1; frame_start = 1'b1; end
         if (n == 201) begin swap_req = 1'b0; frame_start = 1'b0; end
         if (n == 300) begin
            check("clr_front_held", 32'(front_page), 0);
            check("clr_pending_held", 32'(swap_pending), 1);
            check("clr_a_hold", 32'(a_dout), 1);
         end
         step();
      end
      check("clr_busy_cycles", 32'(n), 32'(NPIX));
      check("clr_done_pending", 32'(swap_pending), 1);

      bad = 0;
      for (int y = 0; y < 120; y++) begin
         for (int x = 0; x < 160; x++) begin
            a_addr = pix(x, y); step();
            if (a_dout !== 1'b1) bad++;
         end
      end
      check("clr_fill_bad_pixels", 32'(bad), 0);
      check("clr_no_swap_yet", 32'(front_page), 0);

      frame_start = 1'b1; step(); frame_start = 1'b0;
      check("post_clr_swap_front", 32'(front_page), 1);
      check("post_clr_swap_pending", 32'(swap_pending), 0);
      b_addr = pix(2, 0); step();
      check("b_cleared_pixel", 32'(b_dout), 1);

      // Page 0 to 0, then start filling with 1 and reset at pixel 500
      clear_colour = 1'b0; clear_req = 1'b1; step(); clear_req = 1'b0;
      wait_idle(n);
      check("clr0_busy_cycles", 32'(n), 32'(NPIX));
      clear_colour = 1'b1; clear_req = 1'b1; step(); clear_req = 1'b0;
      repeat (500) step();
      reset = 1'b1; step(); reset = 1'b0;
      check("abort_busy", 32'(a_busy), 0);
      check("abort_front", 32'(front_page), 0);
      foreach (plist[i]) begin
         p = plist[i];
         b_addr = pix(p % 160, p / 160); step();
         check($sformatf("abort_pix_%0d", p), 32'(b_dout), (p < 500) ? 1 : 0);
      end
      a_addr = pix(0, 0); step();
      check("abort_back_page", 32'(a_dout), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/frame_buffer_dp.md
# frame_buffer_dp

Parametrised, single-clock, double-buffered frame buffer with a hardware clear engine; the successor to the 160x120 1-bpp two-port buffer. The microprocessor draws into the back page through port A while the VGA generator scans the front page through port B. Page swaps are deferred to frame boundaries so scan-out never tears. A fill FSM clears the back page to a programmable colour without processor involvement.

## Interface
- H_RES, 160, visible pixels per line; writes/reads with X >= H_RES are out of range
- V_RES, 120, visible lines; Y >= V_RES is out of range
- X_BITS, 8, width of X coordinate
- Y_BITS, 7, width of Y coordinate
- BPP, 1, bits per pixel (colour width)
- CLK  in  1  single clock for both ports and all control
- RESET  in  1  synchronous, active-high reset
- A_ADDR  in  X_BITS+Y_BITS  port A pixel address, {Y, X}: X in [X_BITS-1:0], Y above it
- A_DATA_IN  in  BPP  colour written when A_WE asserted
- A_WE  in  1  port A write enable; back page only
- A_DATA_OUT  out  BPP  registered back-page read of A_ADDR
- A_BUSY  out  1  high while the clear engine owns port A
- B_ADDR  in  X_BITS+Y_BITS  port B pixel address, {Y, X}
- B_DATA_OUT  out  BPP  registered front-page read of B_ADDR
- CLEAR_REQ  in  1  one-cycle pulse: fill back page with CLEAR_COLOUR
- CLEAR_COLOUR  in  BPP  fill colour, sampled on the CLEAR_REQ cycle
- SWAP_REQ  in  1  one-cycle pulse: request front/back exchange
- FRAME_START  in  1  one-cycle pulse from VGA generator at start of vertical blank
- SWAP_PENDING  out  1  swap requested but not yet applied
- FRONT_PAGE  out  1  index of page currently scanned by port B

## Operation
- Memory: two pages, depth 2^(1+Y_BITS+X_BITS) x BPP; physical address {page, Y, X}. Back page = ~FRONT_PAGE.
- Port A (IDLE only): if A_WE and address in range, write back page. A_DATA_OUT returns old contents (read-before-write). Out-of-range: write dropped, A_DATA_OUT = 0.
- Port B: B_DATA_OUT = front page at B_ADDR; out-of-range returns 0.
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on CLEAR_REQ; latch colour; X=Y=0; A_BUSY=1 from next cycle.
  - CLEAR writes one pixel per cycle, X-major, 0..H_RES-1 then Y++. After (H_RES-1, V_RES-1) -> IDLE. Duration exactly H_RES*V_RES cycles (19200 default).
  - In CLEAR: A_WE ignored, A_DATA_OUT holds last value, CLEAR_REQ ignored.
- Swap: SWAP_REQ sets SWAP_PENDING (repeat requests merge). On FRAME_START with SWAP_PENDING=1 and FSM in IDLE: FRONT_PAGE toggles, SWAP_PENDING clears. If FSM in CLEAR, the swap waits for the first FRAME_START after clear completes.
- Simultaneous events:
  - SWAP_REQ and FRAME_START in the same cycle: swap applies on that edge.
  - A_WE and CLEAR_REQ in the same IDLE cycle: the write lands, then the clear overwrites it.
- Memory contents are not reset; undefined at power-up.

## Timing
- Reset values: A_DATA_OUT=0, B_DATA_OUT=0, A_BUSY=0, SWAP_PENDING=0, FRONT_PAGE=0, FSM=IDLE, clear counters=0.
- Reset mid-clear aborts: FSM->IDLE, partial fill retained.
- Read latency on both ports: 1 cycle (data valid the edge after the address).
- Write visible to a port A read on the next cycle; to port B only after a swap.
- FRONT_PAGE updates on the edge sampling FRAME_START. A port B address presented the following cycle reads the new page.
- A_BUSY rises the edge after CLEAR_REQ and falls the edge after the last fill write.

## Structure
- Shared package fb_pkg: clear-state encodings (FB_IDLE, FB_CLEAR), default resolution constants, {page,Y,X} address-pack function.
- Sub-module fb_page_ram: single-clock simple dual-port RAM. One write/read port, one read port, both registered, read-before-write.
- Top holds the clear FSM, swap logic, range checks and output muxing.

## Test plan
- Reset, write 1 at (5,3), read via port A -> A_DATA_OUT=1 next cycle; port B at (5,3) -> 0 (front page untouched).
- SWAP_REQ, then FRAME_START 10 cycles later -> FRONT_PAGE 0->1, SWAP_PENDING 1->0; port B at (5,3) returns 1.
- CLEAR_REQ with CLEAR_COLOUR=1 -> A_BUSY high for exactly 19200 cycles; A_WE during that window is ignored; afterwards all 19200 back-page pixels read 1.
- SWAP_REQ plus FRAME_START mid-clear -> FRONT_PAGE unchanged, SWAP_PENDING stays 1; swap happens on the first FRAME_START after A_BUSY falls.
- Write to (160,0) and (0,120) -> memory unchanged; reads of those addresses return 0 on both ports.
- RESET at clear pixel 500 -> A_BUSY=0 next cycle; pixels 0..499 cleared, pixel 500 onward retain old values.
